// File: rtl/hdmi_pkg.sv
// Shared constants for the tile-grid HDMI renderer.
//  - 640x480@60 raster timing defaults
//  - joystick direction codes and a helper that maps any code to a latched direction
//  - player, grid and background colours (RGB 8:8:8)
package hdmi_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam bit          SYNC_POL_DEF = 1'b0;

  localparam logic [1:0] JOY_NONE = 2'b00;
  localparam logic [1:0] JOY_POS  = 2'b01;
  localparam logic [1:0] JOY_NEG  = 2'b10;

  // Index 0 is the least significant entry.
  localparam logic [3:0][23:0] PLAYER_COLOR = {24'hFFFF00, 24'h0000FF, 24'h00FF00, 24'hFF0000};
  localparam logic [23:0]      GRID_COLOR   = 24'h202020;
  localparam logic [23:0]      BG_COLOR     = 24'h000000;

  // 00 and 11 both mean "no direction".
  function automatic logic [1:0] joy_sanitize(input logic [1:0] code);
    return (code == JOY_POS || code == JOY_NEG) ? code : JOY_NONE;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters and combinational (unregistered) timing strobes.
//  clk, reset_n   pixel clock, async active-low reset
//  h_cnt, v_cnt   current pixel / line position
//  active         h_cnt < H_ACTIVE and v_cnt < V_ACTIVE
//  hsync, vsync   level SYNC_POL inside the sync window, ~SYNC_POL otherwise
//  first_pixel    h_cnt == 0 and v_cnt == 0
//  tick           h_cnt == 0 and v_cnt == V_ACTIVE (start of vertical blanking)
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int unsigned V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           first_pixel,
  output logic           tick
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_W'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign active      = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
  assign hsync       = ((h_q >= H_W'(H_ACTIVE + H_FP)) && (h_q < H_W'(H_ACTIVE + H_FP + H_SYNC)))
                       ? SYNC_POL : ~SYNC_POL;
  assign vsync       = ((v_q >= V_W'(V_ACTIVE + V_FP)) && (v_q < V_W'(V_ACTIVE + V_FP + V_SYNC)))
                       ? SYNC_POL : ~SYNC_POL;
  assign first_pixel = (h_q == '0) && (v_q == '0);
  assign tick        = (h_q == '0) && (v_q == V_W'(V_ACTIVE));

endmodule

// File: rtl/hdmi_grid_display.sv
// Raster timing plus tile-grid renderer for N joystick-driven players.
//  clk, reset_n          pixel clock, async active-low reset
//  x_axis, y_axis        per player [2i+1:2i]; x: 01 right, 10 left; y: 01 up, 10 down
//  hsync, vsync, de      registered timing, 2 clk behind the raster counters
//  pixel                 RGB 8:8:8, same latency as de
//  frame_start           pulse aligned with the first active pixel of each frame
//  collision             sticky per-player same-tile flags, cleared only by reset
module hdmi_grid_display
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF,
  parameter bit          SYNC_POL  = SYNC_POL_DEF,
  parameter int unsigned TILE_LOG2 = 4,
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned MOVE_DIV  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2*N_PLAYERS-1:0] x_axis,
  input  logic [2*N_PLAYERS-1:0] y_axis,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [23:0]            pixel,
  output logic                   frame_start,
  output logic [N_PLAYERS-1:0]   collision
);
  localparam int unsigned H_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned V_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int unsigned COLS  = H_ACTIVE >> TILE_LOG2;
  localparam int unsigned ROWS  = V_ACTIVE >> TILE_LOG2;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [H_W-1:0] TILE_MASK_H = H_W'((1 << TILE_LOG2) - 1);
  localparam logic [V_W-1:0] TILE_MASK_V = V_W'((1 << TILE_LOG2) - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           active, hs_raw, vs_raw, first_pixel, tick;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hsync       (hs_raw),
    .vsync       (vs_raw),
    .first_pixel (first_pixel),
    .tick        (tick)
  );

  // Player state: direction latches, frame divider, positions, collision flags.
  logic [N_PLAYERS-1:0][1:0]       x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic [N_PLAYERS-1:0][COL_W-1:0] col_q, col_d;
  logic [N_PLAYERS-1:0][ROW_W-1:0] row_q, row_d;
  logic [N_PLAYERS-1:0]            coll_q, coll_d;
  logic [DIV_W-1:0]                div_q, div_d;
  logic                            step, step_q;

  assign step = tick && (div_q == DIV_W'(MOVE_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (tick) div_d = step ? '0 : div_q + 1'b1;
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      x_dir_d[i] = joy_sanitize(x_axis[2*i +: 2]);
      y_dir_d[i] = joy_sanitize(y_axis[2*i +: 2]);
      col_d[i]   = col_q[i];
      row_d[i]   = row_q[i];
      if (step) begin
        case (x_dir_q[i])
          JOY_POS: col_d[i] = (col_q[i] == COL_W'(COLS - 1)) ? '0 : col_q[i] + 1'b1;
          JOY_NEG: col_d[i] = (col_q[i] == '0) ? COL_W'(COLS - 1) : col_q[i] - 1'b1;
          default: ;
        endcase
        // Up moves toward row 0.
        case (y_dir_q[i])
          JOY_POS: row_d[i] = (row_q[i] == '0) ? ROW_W'(ROWS - 1) : row_q[i] - 1'b1;
          JOY_NEG: row_d[i] = (row_q[i] == ROW_W'(ROWS - 1)) ? '0 : row_q[i] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Compared the cycle after a step, when positions already hold the new values.
  always_comb begin
    coll_d = coll_q;
    if (step_q) begin
      for (int i = 0; i < int'(N_PLAYERS); i++) begin
        for (int j = i + 1; j < int'(N_PLAYERS); j++) begin
          if (col_q[i] == col_q[j] && row_q[i] == row_q[j]) begin
            coll_d[i] = 1'b1;
            coll_d[j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      step_q  <= 1'b0;
      coll_q  <= '0;
      x_dir_q <= '0;
      y_dir_q <= '0;
      for (int i = 0; i < int'(N_PLAYERS); i++) begin
        col_q[i] <= COL_W'(COLS * (i + 1) / (N_PLAYERS + 1));
        row_q[i] <= ROW_W'(ROWS / 2);
      end
    end else begin
      div_q   <= div_d;
      step_q  <= step;
      coll_q  <= coll_d;
      x_dir_q <= x_dir_d;
      y_dir_q <= y_dir_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign collision = coll_q;

  // Stage 1: tile coordinate, hit compare, grid-line detect.
  logic [COL_W-1:0]     tile_x;
  logic [ROW_W-1:0]     tile_y;
  logic [N_PLAYERS-1:0] hit;
  logic [N_PLAYERS-1:0] s1_hit;
  logic                 s1_de, s1_hsync, s1_vsync, s1_fs, s1_grid;

  assign tile_x = COL_W'(h_cnt >> TILE_LOG2);
  assign tile_y = ROW_W'(v_cnt >> TILE_LOG2);

  always_comb begin
    for (int i = 0; i < int'(N_PLAYERS); i++) begin
      hit[i] = (col_q[i] == tile_x) && (row_q[i] == tile_y);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_de    <= 1'b0;
      s1_hsync <= ~SYNC_POL;
      s1_vsync <= ~SYNC_POL;
      s1_fs    <= 1'b0;
      s1_grid  <= 1'b0;
      s1_hit   <= '0;
    end else begin
      s1_de    <= active;
      s1_hsync <= hs_raw;
      s1_vsync <= vs_raw;
      s1_fs    <= first_pixel;
      s1_grid  <= ((h_cnt & TILE_MASK_H) == '0) || ((v_cnt & TILE_MASK_V) == '0);
      s1_hit   <= hit;
    end
  end

  // Stage 2: colour mux; lowest-index player wins, then grid, then background.
  logic [23:0] pix_d;

  always_comb begin
    pix_d = '0;
    if (s1_de) begin
      pix_d = s1_grid ? GRID_COLOR : BG_COLOR;
      for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
        if (s1_hit[i]) pix_d = PLAYER_COLOR[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= s1_hsync;
      vsync       <= s1_vsync;
      de          <= s1_de;
      pixel       <= pix_d;
      frame_start <= s1_fs;
    end
  end

endmodule

// File: tb/tb_hdmi_grid_display.sv
// Bench for hdmi_grid_display on a shrunken raster (40x30 total, 32x24 active, 4 px tiles)
// so that many movement steps fit in a short run. Every output is compared each cycle
// against a frame-level model of positions, colours and timing windows.
module tb_hdmi_grid_display;
  localparam int unsigned HA = 32, HFP = 2, HS = 4, HB = 2;
  localparam int unsigned VA = 24, VFP = 2, VS = 2, VB = 2;
  localparam int unsigned HT = HA + HFP + HS + HB;
  localparam int unsigned VT = VA + VFP + VS + VB;
  localparam int unsigned TL = 2, TILE = 4, COLS = 8, ROWS = 6;
  localparam int unsigned NP = 2, MD = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  x_axis = '0;
  logic [3:0]  y_axis = '0;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] pixel;
  logic [1:0]  collision;

  always #5 clk = ~clk;

  hdmi_grid_display #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
    .SYNC_POL (1'b0), .TILE_LOG2 (TL), .N_PLAYERS (NP), .MOVE_DIV (MD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x_axis      (x_axis),
    .y_axis      (y_axis),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .pixel       (pixel),
    .frame_start (frame_start),
    .collision   (collision)
  );

  int checks = 0;
  int failures = 0;

  // Model state.
  int unsigned k;          // clock edges since reset release
  int          col_m [NP];
  int          row_m [NP];
  int          ticks_m;
  logic [1:0]  coll_m;
  logic [23:0] pcol [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00};
  localparam logic [23:0] GRID = 24'h202020, BG = 24'h000000;
  localparam logic [31:0] RST_OUT = {4'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    ticks_m = 0;
    coll_m = '0;
    for (int i = 0; i < NP; i++) begin
      col_m[i] = COLS * (i + 1) / (NP + 1);
      row_m[i] = ROWS / 2;
    end
  endtask

  // Outputs seen after edge kk describe raster position kk-2.
  function automatic logic [31:0] exp_out(input int unsigned kk);
    int unsigned m, h, v;
    logic hs, vs, act, fs, found;
    logic [23:0] px;
    if (kk < 2) return RST_OUT;
    m   = kk - 2;
    h   = m % HT;
    v   = (m / HT) % VT;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
    vs  = (v >= VA + VFP && v < VA + VFP + VS) ? 1'b0 : 1'b1;
    fs  = (h == 0) && (v == 0);
    px  = '0;
    if (act) begin
      found = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (!found && col_m[i] == int'(h / TILE) && row_m[i] == int'(v / TILE)) begin
          px = pcol[i];
          found = 1'b1;
        end
      end
      if (!found) px = ((h % TILE) == 0 || (v % TILE) == 0) ? GRID : BG;
    end
    return {4'b0, hs, vs, act, fs, px};
  endfunction

  task automatic apply_step();
    logic [1:0] xc, yc;
    for (int i = 0; i < NP; i++) begin
      xc = x_axis[2*i +: 2];
      yc = y_axis[2*i +: 2];
      if (xc == 2'b01) col_m[i] = (col_m[i] + 1) % COLS;
      else if (xc == 2'b10) col_m[i] = (col_m[i] + COLS - 1) % COLS;
      if (yc == 2'b01) row_m[i] = (row_m[i] + ROWS - 1) % ROWS;
      else if (yc == 2'b10) row_m[i] = (row_m[i] + 1) % ROWS;
    end
    if (col_m[0] == col_m[1] && row_m[0] == row_m[1]) coll_m = 2'b11;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    k++;
    check("video", {4'b0, hsync, vsync, de, frame_start, pixel}, exp_out(k));
    if ((k % (HT * VT)) == 0) check("collision", {30'b0, collision}, {30'b0, coll_m});
    // Raster position k is the movement tick.
    if ((k % HT) == 0 && ((k / HT) % VT) == VA) begin
      ticks_m++;
      if ((ticks_m % MD) == 0) apply_step();
    end
  endtask

  // Two frames with fixed inputs: exactly one movement step.
  task automatic run_pair(input logic [3:0] xv, input logic [3:0] yv);
    x_axis = xv;
    y_axis = yv;
    repeat (2 * HT * VT) cycle();
  endtask

  initial begin
    // Reset takes effect without a clock edge.
    #2 reset_n = 1'b0;
    #1;
    check("reset_async", {4'b0, hsync, vsync, de, frame_start, pixel}, RST_OUT);
    check("reset_coll", {30'b0, collision}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    run_pair(4'b0001, 4'b0000);   // p0 right: col 2 -> 3
    run_pair(4'b1001, 4'b0000);   // toward each other: both at col 4 -> collision
    run_pair(4'b1001, 4'b0000);   // pass through, flags stay set
    repeat (3) run_pair(4'b0001, 4'b0000);   // p0 right wraps 7 -> 0
    run_pair(4'b0010, 4'b0000);   // p0 left wraps 0 -> 7
    repeat (4) run_pair(4'b0000, 4'b0001);   // p0 up wraps 0 -> ROWS-1
    run_pair(4'b0000, 4'b0010);   // p0 down wraps ROWS-1 -> 0
    run_pair(4'b1111, 4'b1111);   // 11 codes: no motion
    run_pair(4'b0000, 4'b0000);
    run_pair(4'b1111, 4'b0000);
    run_pair(4'b0001, 4'b0010);   // diagonal

    // Mid-line reset, then fresh start from h = v = 0 with flags cleared.
    repeat (HT * 5 + 17) cycle();
    #2 reset_n = 1'b0;
    #1;
    check("midreset_out", {4'b0, hsync, vsync, de, frame_start, pixel}, RST_OUT);
    check("midreset_coll", {30'b0, collision}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("midreset_hold", {4'b0, hsync, vsync, de, frame_start, pixel}, RST_OUT);
    reset_n = 1'b1;
    model_reset();

    for (int n = 0; n < 5; n++) begin
      run_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
